song_player: RTL and testbench
==============================

# song_player

Sequencer directly downstream of the song note memory. On a start pulse it reads notes one at a time: address out, one-hot 10-bit note back with one cycle of read latency. It holds each note for a fixed beat, drives a square-wave buzzer at that note's pitch, and mirrors the note onto the LED bus. It then advances to the next note until the song length is reached, supporting pause and stop along the way.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz
- BEAT_CYCLES, 25_000_000, clock cycles per note slot; must be > GAP_CYCLES
- GAP_CYCLES, 2_500_000, silent cycles at the end of each slot, for articulation between repeated notes
- SONG_LEN, 14, number of notes played, from address 0 to SONG_LEN-1; 1 ≤ SONG_LEN ≤ 2**ADDR_W
- ADDR_W, 7, note memory address width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins playback from address 0
- pause  in  1  level; while high, playback freezes
- stop  in  1  one-cycle pulse that aborts playback
- mem_addr  out  ADDR_W  note memory read address
- mem_data  in  10  one-hot note from memory, valid one cycle after mem_addr
- note_onehot  out  10  note currently sounding, to the LEDs
- buzzer  out  1  square-wave tone output
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the final note completes

## Operation
- Note decode, by bit index of mem_data:
  - 0 DO 523 Hz, 1 RE 587, 2 MI 659, 3 FA 698, 4 SO 784, 5 LA 880, 6 SI 988.
  - Bits 7–9 are reserved; treat them as rest.
  - Half-period HP = CLK_HZ/(2·f), integer truncation, computed at elaboration.
  - All-zero or multi-hot words are rests: buzzer stays 0 and note_onehot shows the raw word.
- States:
  - IDLE: start → FETCH, with idx=0.
  - FETCH: drive mem_addr=idx for one cycle → LOAD.
  - LOAD: capture mem_data into the note register, clear the beat and tone counters → PLAY.
  - PLAY: the beat counter runs from 0 to BEAT_CYCLES-1. At the last count:
    - if idx==SONG_LEN-1 → DONE;
    - otherwise idx+1 → FETCH.
  - DONE: pulse done for one cycle → IDLE.
- Tone, in PLAY while beat count < BEAT_CYCLES-GAP_CYCLES:
  - The tone counter counts 0 to HP-1; at HP-1 it wraps and buzzer toggles.
  - buzzer is 0 at PLAY entry.
- Gap, while beat count ≥ BEAT_CYCLES-GAP_CYCLES:
  - buzzer is forced 0 and note_onehot=0.
  - The tone counter is held at 0.
- Pause (high in PLAY):
  - The beat and tone counters freeze and buzzer is forced 0.
  - note_onehot keeps its value.
  - On release, counting resumes from the frozen values with buzzer starting at 0.
  - pause in FETCH or LOAD has no effect; it takes hold on the first PLAY cycle.
- stop in any state:
  - Next state is IDLE.
  - note_onehot, buzzer and idx are cleared; mem_addr goes to 0.
  - No done pulse is issued.
- Priorities:
  - stop beats start.
  - start while busy is ignored.
  - start in the DONE cycle is ignored.
- Counter widths are $clog2 of their maximum value, minimum 1. idx has width ADDR_W.

## Timing
- Reset values: mem_addr=0, note_onehot=0, buzzer=0, busy=0, done=0. State is IDLE, idx=0.
- start sampled at edge 0:
  - FETCH in cycle 1, with mem_addr=0 registered.
  - LOAD in cycle 2.
  - note_onehot valid from cycle 3, the first PLAY cycle.
- Each note slot takes BEAT_CYCLES+2 cycles. Un-paused song length is SONG_LEN·(BEAT_CYCLES+2) cycles.
- The first buzzer rise comes HP cycles after PLAY entry.
- done rises the cycle after the final PLAY cycle. busy falls with the transition to IDLE.
- Reset asserted mid-song returns all outputs to reset values immediately; no done pulse is issued.
- All outputs are registered.

## Test plan
Default parameters for all scenarios: CLK_HZ=10_000, BEAT_CYCLES=100, GAP_CYCLES=10, SONG_LEN=3. HP values are DO=9, RE=8, SO=6.
- Memory holds [DO, DO, SO]; pulse start → note_onehot=0x001 over cycles 3–92, 0 over 93–102, 0x001 again from 105, 0x010 from 207. done pulses once at cycle 307; busy=0 from 308.
- First DO slot → buzzer toggles every 9 cycles, 5 rising edges within 90 cycles, 0 during the gap. SO slot → toggles every 6 cycles.
- pause held 20 cycles at beat count 40 → buzzer=0 and note held for those cycles; done is delayed by exactly 20 cycles.
- stop at cycle 150 → busy=0, note_onehot=0, buzzer=0, mem_addr=0 next cycle, no done. A start 5 cycles later replays from address 0.
- start reasserted mid-song, and start+stop in the same cycle while in IDLE → both ignored; playback timing matches the first scenario.
- Memory word 0x000 at address 1, and rst_n pulsed low mid-PLAY → slot 2 is silent with note_onehot=0. During reset all outputs are 0 asynchronously.

Source files
------------

// File: rtl/song_player.sv
// Song sequencer: fetches one-hot notes from memory, holds each for a beat,
// and drives a square-wave buzzer plus LED mirror of the current note.
module song_player #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 2_500_000,
    parameter int SONG_LEN    = 14,
    parameter int ADDR_W      = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic              stop,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [9:0]        mem_data,
    output logic [9:0]        note_onehot,
    output logic              buzzer,
    output logic              busy,
    output logic              done
);

    localparam int HP_DO = CLK_HZ / (2 * 523);
    localparam int HP_RE = CLK_HZ / (2 * 587);
    localparam int HP_MI = CLK_HZ / (2 * 659);
    localparam int HP_FA = CLK_HZ / (2 * 698);
    localparam int HP_SO = CLK_HZ / (2 * 784);
    localparam int HP_LA = CLK_HZ / (2 * 880);
    localparam int HP_SI = CLK_HZ / (2 * 988);

    // DO has the lowest pitch, hence the longest half-period.
    localparam int TONE_W = (HP_DO > 1) ? $clog2(HP_DO) : 1;
    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [BEAT_W:0]   GAP_START =
        (BEAT_W + 1)'(BEAT_CYCLES - GAP_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        DONE
    } state_t;

    state_t state;
    state_t stateNext;

    logic [ADDR_W-1:0] idx;
    logic [9:0]        noteReg;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] beatNext;
    logic [TONE_W-1:0] toneCnt;
    logic [TONE_W-1:0] hpLast;
    logic              toneValid;
    logic              beatLast;
    logic              lastNote;
    logic              inTone;
    logic              inGapNext;
    logic              toneWrap;

    // Only a single hot bit among the seven pitch bits produces a tone.
    always_comb begin
        toneValid = 1'b1;
        hpLast    = '0;
        case (noteReg)
            10'h001: hpLast = TONE_W'(HP_DO - 1);
            10'h002: hpLast = TONE_W'(HP_RE - 1);
            10'h004: hpLast = TONE_W'(HP_MI - 1);
            10'h008: hpLast = TONE_W'(HP_FA - 1);
            10'h010: hpLast = TONE_W'(HP_SO - 1);
            10'h020: hpLast = TONE_W'(HP_LA - 1);
            10'h040: hpLast = TONE_W'(HP_SI - 1);
            default: toneValid = 1'b0;
        endcase
    end

    always_comb begin
        beatNext  = beat + 1'b1;
        beatLast  = (beat == BEAT_LAST);
        lastNote  = (idx == LAST_IDX);
        inTone    = ({1'b0, beat} < GAP_START);
        inGapNext = ({1'b0, beatNext} >= GAP_START);
        toneWrap  = (toneCnt == hpLast);
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:  if (start) stateNext = FETCH;
            FETCH: stateNext = LOAD;
            LOAD:  stateNext = PLAY;
            PLAY: begin
                if (!pause && beatLast) begin
                    stateNext = lastNote ? DONE : FETCH;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (stop) stateNext = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            mem_addr    <= '0;
            noteReg     <= '0;
            note_onehot <= '0;
            beat        <= '0;
            toneCnt     <= '0;
            buzzer      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            busy <= (stateNext != IDLE);
            done <= (stateNext == DONE);
            if (stop) begin
                idx         <= '0;
                mem_addr    <= '0;
                note_onehot <= '0;
                buzzer      <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            idx      <= '0;
                            mem_addr <= '0;
                        end
                    end
                    FETCH: ;
                    LOAD: begin
                        noteReg     <= mem_data;
                        note_onehot <= mem_data;
                        beat        <= '0;
                        toneCnt     <= '0;
                        buzzer      <= 1'b0;
                    end
                    PLAY: begin
                        if (pause) begin
                            buzzer <= 1'b0;
                        end else if (beatLast) begin
                            buzzer <= 1'b0;
                            if (!lastNote) begin
                                idx      <= idx + 1'b1;
                                mem_addr <= idx + 1'b1;
                            end
                        end else begin
                            beat <= beatNext;
                            if (inTone && toneValid) begin
                                toneCnt <= toneWrap ? '0 : toneCnt + 1'b1;
                                if (toneWrap) buzzer <= ~buzzer;
                            end else begin
                                toneCnt <= '0;
                            end
                            // Entering the articulation gap silences everything.
                            if (inGapNext) begin
                                buzzer      <= 1'b0;
                                note_onehot <= '0;
                            end
                        end
                    end
                    DONE: begin
                        idx      <= '0;
                        mem_addr <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_player.sv
// Bench for song_player: behavioural note-slot model checked every cycle,
// plus directed literal checks of playback timing, pause, stop and reset.
module tb_song_player;

    localparam int CLK_HZ = 10_000;
    localparam int BEAT   = 100;
    localparam int GAP    = 10;
    localparam int LEN    = 3;
    localparam int AW     = 7;

    localparam logic [9:0] DO = 10'h001;
    localparam logic [9:0] SO = 10'h010;

    localparam int FREQ [7] = '{523, 587, 659, 698, 784, 880, 988};
    localparam logic [9:0] WORDS [13] = '{
        10'h001, 10'h002, 10'h004, 10'h008, 10'h010, 10'h020, 10'h040,
        10'h080, 10'h100, 10'h200, 10'h000, 10'h003, 10'h0C0
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          stop = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [9:0]    mem_data = '0;
    logic [9:0]    note_onehot;
    logic          buzzer;
    logic          busy;
    logic          done;

    logic [9:0] mem [0:127];

    int nVec = 0;
    int nErr = 0;

    // Model: active flag, slot index, position in slot (0 fetch, 1 load, 2+ beat).
    bit            mAct = 1'b0;
    int            mPos = 0;
    int            mSlot = 0;
    logic [AW-1:0] eAddr = '0;
    logic [9:0]    eNote = '0;
    bit            eBuz = 1'b0;
    bit            eBusy = 1'b0;
    bit            eDone = 1'b0;

    always #5 clk = ~clk;

    song_player #(
        .CLK_HZ(CLK_HZ),
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES(GAP),
        .SONG_LEN(LEN),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .pause(pause),
        .stop(stop),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .note_onehot(note_onehot),
        .buzzer(buzzer),
        .busy(busy),
        .done(done)
    );

    always @(posedge clk) mem_data <= mem[mem_addr];

    function automatic int hpOf(logic [9:0] w);
        if ($countones(w) != 1 || w[9:7] != 3'b000) return 0;
        for (int i = 0; i < 7; i++) begin
            if (w[i]) return CLK_HZ / (2 * FREQ[i]);
        end
        return 0;
    endfunction

    task automatic modelReset();
        mAct = 1'b0; mPos = 0; mSlot = 0;
        eAddr = '0; eNote = '0; eBuz = 1'b0; eBusy = 1'b0; eDone = 1'b0;
    endtask

    task automatic modelStep();
        int b;
        int hp;
        if (stop) begin
            modelReset();
        end else if (eDone) begin
            eDone = 1'b0; eBusy = 1'b0; eAddr = '0; mSlot = 0;
        end else if (!mAct) begin
            if (start) begin
                mAct = 1'b1; mSlot = 0; mPos = 0; eAddr = '0; eBusy = 1'b1;
            end
        end else if (mPos == 0) begin
            mPos = 1;
        end else if (mPos == 1) begin
            mPos = 2; eNote = mem[mSlot]; eBuz = 1'b0;
        end else begin
            b = mPos - 2;
            if (pause) begin
                eBuz = 1'b0;
            end else if (b == BEAT - 1) begin
                eBuz = 1'b0;
                if (mSlot == LEN - 1) begin
                    mAct = 1'b0; eDone = 1'b1;
                end else begin
                    mSlot++; mPos = 0; eAddr = AW'(mSlot);
                end
            end else begin
                hp = hpOf(mem[mSlot]);
                mPos++;
                if (b + 1 >= BEAT - GAP) begin
                    eNote = '0; eBuz = 1'b0;
                end else if (hp > 0 && (b % hp) == hp - 1) begin
                    eBuz = !eBuz;
                end
            end
        end
    endtask

    initial begin : modelProc
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: actual %0h required %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        chk("mem_addr", 32'(mem_addr), 32'(eAddr));
        chk("note_onehot", 32'(note_onehot), 32'(eNote));
        chk("buzzer", 32'(buzzer), 32'(eBuz));
        chk("busy", 32'(busy), 32'(eBusy));
        chk("done", 32'(done), 32'(eDone));
    endtask

    // Start is sampled at edge 0; returns at the negedge of cycle 1.
    task automatic go();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    initial begin : main
        int doneCnt, doneAt, rises, firstRise, bad, pl;
        bit prevBuz;
        for (int i = 0; i < 128; i++) mem[i] = '0;
        #1 rst_n = 1'b0;
        repeat (3) cycle();
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_note", 32'(note_onehot), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        cycle();

        // Baseline song DO, DO, SO.
        mem[0] = DO; mem[1] = DO; mem[2] = SO;
        doneCnt = 0; doneAt = -1; rises = 0; firstRise = -1; bad = 0;
        prevBuz = 1'b0;
        go();
        for (int n = 1; n <= 312; n++) begin
            if (n == 1) chk("s1_fetch_addr", 32'(mem_addr), 0);
            if (n == 3 || n == 92 || n == 105)
                chk("s1_note_do", 32'(note_onehot), 32'(DO));
            if (n == 93 || n == 102) chk("s1_note_gap", 32'(note_onehot), 0);
            if (n == 207) chk("s1_note_so", 32'(note_onehot), 32'(SO));
            if (n == 212 || n == 219) chk("s1_so_low", 32'(buzzer), 0);
            if (n == 213) chk("s1_so_rise", 32'(buzzer), 1);
            if (n == 308) chk("s1_busy_end", 32'(busy), 0);
            if (n >= 3 && n <= 92 && buzzer && !prevBuz) begin
                rises++;
                if (firstRise < 0) firstRise = n;
            end
            if (n >= 93 && n <= 102 && buzzer) bad++;
            if (done) begin doneCnt++; doneAt = n; end
            prevBuz = buzzer;
            cycle();
        end
        chk("s1_do_rises", 32'(rises), 5);
        chk("s1_first_rise", 32'(firstRise), 12);
        chk("s1_gap_silent", 32'(bad), 0);
        chk("s1_done_cnt", 32'(doneCnt), 1);
        chk("s1_done_at", 32'(doneAt), 307);

        // Pause for 20 cycles at beat 40 of the first slot.
        doneCnt = 0; doneAt = -1; bad = 0;
        go();
        for (int n = 1; n <= 335; n++) begin
            if (n >= 44 && n <= 63 && (buzzer || note_onehot != DO)) bad++;
            if (done) begin doneCnt++; doneAt = n; end
            pause = (n >= 43 && n <= 62);
            cycle();
        end
        pause = 1'b0;
        chk("pz_held", 32'(bad), 0);
        chk("pz_done_cnt", 32'(doneCnt), 1);
        chk("pz_done_at", 32'(doneAt), 327);

        // Stop at cycle 150, restart 5 cycles later.
        doneCnt = 0; doneAt = -1;
        go();
        for (int n = 1; n <= 470; n++) begin
            if (n == 151) begin
                chk("st_busy", 32'(busy), 0);
                chk("st_note", 32'(note_onehot), 0);
                chk("st_buz", 32'(buzzer), 0);
                chk("st_addr", 32'(mem_addr), 0);
            end
            if (n == 156) chk("st_refetch", 32'(busy), 1);
            if (n == 158) chk("st_renote", 32'(note_onehot), 32'(DO));
            if (done) begin doneCnt++; doneAt = n; end
            stop = (n == 150);
            start = (n == 155);
            cycle();
        end
        chk("st_done_cnt", 32'(doneCnt), 1);
        chk("st_done_at", 32'(doneAt), 462);

        // start+stop together in idle, then a start re-pulsed mid-song.
        start = 1'b1; stop = 1'b1;
        cycle();
        start = 1'b0; stop = 1'b0;
        chk("ss_idle", 32'(busy), 0);
        doneCnt = 0; doneAt = -1;
        go();
        for (int n = 1; n <= 312; n++) begin
            if (n == 207) chk("rs_note_so", 32'(note_onehot), 32'(SO));
            if (done) begin doneCnt++; doneAt = n; end
            start = (n == 120);
            cycle();
        end
        chk("rs_done_cnt", 32'(doneCnt), 1);
        chk("rs_done_at", 32'(doneAt), 307);

        // Rest word at address 1, then asynchronous reset mid-PLAY.
        mem[1] = 10'h000;
        doneCnt = 0; bad = 0;
        go();
        for (int n = 1; n <= 330; n++) begin
            if (n >= 105 && n <= 204 && (buzzer || note_onehot != 0)) bad++;
            if (n == 207) chk("rr_note_so", 32'(note_onehot), 32'(SO));
            if (done) doneCnt++;
            if (n == 230) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rr_async_note", 32'(note_onehot), 0);
                chk("rr_async_busy", 32'(busy), 0);
                chk("rr_async_addr", 32'(mem_addr), 0);
                chk("rr_async_buz", 32'(buzzer), 0);
            end
            if (n == 233) rst_n = 1'b1;
            cycle();
        end
        chk("rr_rest_silent", 32'(bad), 0);
        chk("rr_no_done", 32'(doneCnt), 0);

        // Randomized songs with random pause, stop and start traffic.
        for (int r = 0; r < 6; r++) begin
            pl = 0;
            start = 1'b0; pause = 1'b0; stop = 1'b1;
            cycle();
            stop = 1'b0;
            for (int a = 0; a < LEN; a++) mem[a] = WORDS[$urandom_range(0, 12)];
            for (int c = 0; c < 1200; c++) begin
                start = ($urandom_range(0, 39) == 0);
                stop = ($urandom_range(0, 599) == 0);
                if (pl == 0 && $urandom_range(0, 24) == 0) pl = $urandom_range(1, 15);
                pause = (pl > 0);
                if (pl > 0) pl--;
                cycle();
            end
        end
        start = 1'b0; pause = 1'b0; stop = 1'b0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
